// File: rtl/serial_frame_deser_pkg.sv
// Shared definitions for the serial frame deserializer: FSM encoding and default
// frame geometry, matched to the upstream right-shift register.
package serial_frame_deser_pkg;

   localparam int unsigned DEF_DW    = 4;
   localparam int unsigned DEF_CNT_W = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_e;

endpackage

// File: rtl/serial_frame_deser_out_buf.sv
// One-deep valid/ready holding register for assembled words; flags a word that
// arrives while the buffer is full and not being drained.
module serial_frame_deser_out_buf #(
   parameter int unsigned DW = serial_frame_deser_pkg::DEF_DW
) (
   input  logic          clk,
   input  logic          sync_rst,
   input  logic          load,
   input  logic [DW-1:0] word,
   input  logic          data_ready,
   output logic [DW-1:0] data_out,
   output logic          data_valid,
   output logic          drop_c
);

   logic accept_c;

   assign accept_c = data_valid && data_ready;
   assign drop_c   = load && data_valid && !data_ready;

   // A load is taken when the slot is empty or is emptied on this very edge.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (load && (!data_valid || data_ready)) begin
         data_out   <= word;
         data_valid <= 1'b1;
      end else if (accept_c) begin
         data_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_frame_deser.sv
// Rebuilds DW-bit LSB-first frames from a serial bit stream and hands them to a
// one-deep valid/ready buffer; a sticky flag records frames lost to back-pressure.
module serial_frame_deser
   import serial_frame_deser_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             sync_rst,
   input  logic             bit_in,
   input  logic             bit_en,
   input  logic             sof,
   output logic [DW-1:0]    data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overrun
);

   state_e           state;
   state_e           state_nx;
   logic [DW-1:0]    shreg;
   logic [DW-1:0]    shreg_nx;
   logic [DW-1:0]    shifted_c;
   logic [CNT_W-1:0] cnt_nx;
   logic             done_c;
   logic             drop_c;

   assign shifted_c = {bit_in, shreg[DW-1:1]};
   assign busy      = (state == ST_RECV);

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         bit_cnt <= cnt_nx;
         if (drop_c) begin
            overrun <= 1'b1;
         end
      end
   end

   // A sof bit always starts a fresh frame, discarding any partial one.
   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      cnt_nx   = bit_cnt;
      done_c   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bit_en && sof) begin
               shreg_nx = shifted_c;
               cnt_nx   = CNT_W'(1);
               state_nx = ST_RECV;
            end
         end
         ST_RECV: begin
            if (bit_en) begin
               shreg_nx = shifted_c;
               if (sof) begin
                  cnt_nx = CNT_W'(1);
               end else if (bit_cnt == CNT_W'(DW - 1)) begin
                  done_c   = 1'b1;
                  cnt_nx   = '0;
                  state_nx = ST_IDLE;
               end else begin
                  cnt_nx = bit_cnt + CNT_W'(1);
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   serial_frame_deser_out_buf #(
      .DW (DW)
   ) u_out_buf (
      .clk        (clk),
      .sync_rst   (sync_rst),
      .load       (done_c),
      .word       (shifted_c),
      .data_ready (data_ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .drop_c     (drop_c)
   );

endmodule

// File: tb/tb_serial_frame_deser.sv
// Directed bench for serial_frame_deser: a frame-level reference model checked every
// cycle, plus literal expectations for each scenario and the accepted-word sequence.
module tb_serial_frame_deser;

   localparam int unsigned DW    = 4;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned NWORD = 8;

   logic             clk = 1'b0;
   logic             sync_rst = 1'b1;
   logic             bit_in = 1'b0;
   logic             bit_en = 1'b0;
   logic             sof = 1'b0;
   logic             data_ready = 1'b1;
   logic [DW-1:0]    data_out;
   logic             data_valid;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;
   logic             overrun;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   serial_frame_deser #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .sync_rst   (sync_rst),
      .bit_in     (bit_in),
      .bit_en     (bit_en),
      .sof        (sof),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .busy       (busy),
      .bit_cnt    (bit_cnt),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bits are placed by position, frames counted in whole bits.
   int            m_n = 0;
   logic [DW-1:0] m_acc = '0;
   logic [DW-1:0] m_data = '0;
   logic          m_valid = 1'b0;
   logic          m_ovr = 1'b0;
   logic          m_done;
   logic [DW-1:0] m_word;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] act_q[$];

   always @(posedge clk) begin
      if (sync_rst) begin
         m_n = 0; m_acc = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
      end else begin
         if (data_valid && data_ready) act_q.push_back(data_out);
         m_done = 1'b0;
         m_word = '0;
         if (bit_en) begin
            if (sof) begin
               m_acc = DW'(bit_in);
               m_n   = 1;
            end else if (m_n > 0) begin
               m_acc = m_acc | (DW'(bit_in) << m_n);
               m_n++;
               if (m_n == int'(DW)) begin
                  m_done = 1'b1;
                  m_word = m_acc;
                  m_n    = 0;
               end
            end
         end
         if (m_valid && data_ready) exp_q.push_back(m_data);
         if (m_done) begin
            if (!m_valid || data_ready) begin
               m_data  = m_word;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && data_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_data_out", 32'(data_out), 32'(m_data));
         check("m_data_valid", 32'(data_valid), 32'(m_valid));
         check("m_busy", 32'(busy), 32'(m_n != 0));
         check("m_bit_cnt", 32'(bit_cnt), 32'(m_n));
         check("m_overrun", 32'(overrun), 32'(m_ovr));
      end
   end

   task automatic cyc(input logic en, input logic b, input logic s);
      @(negedge clk);
      bit_en = en;
      bit_in = b;
      sof    = s;
   endtask

   task automatic send_frame(input logic [DW-1:0] w);
      for (int i = 0; i < int'(DW); i++) cyc(1'b1, w[i], i == 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bit_en = 1'b0; sof = 1'b0; bit_in = 1'b0;
      sync_rst = 1'b1;
      @(negedge clk);
      sync_rst = 1'b0;
   endtask

   logic [DW-1:0] lit_q [NWORD];
   logic [DW-1:0] rs;

   initial begin
      lit_q = '{4'hD, 4'hD, 4'h6, 4'hF, 4'hA, 4'hC, 4'h3, 4'h9};
      repeat (2) @(negedge clk);
      sync_rst = 1'b0;
      chk_en = 1'b1;
      check("rst_valid", 32'(data_valid), 32'h0);
      check("rst_data", 32'(data_out), 32'h0);

      // 1: reset mid-frame, then a clean frame
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      do_reset();
      check("t1_busy", 32'(busy), 32'h0);
      check("t1_cnt", 32'(bit_cnt), 32'h0);
      check("t1_valid", 32'(data_valid), 32'h0);
      check("t1_ovr", 32'(overrun), 32'h0);
      send_frame(4'hD);
      cyc(1'b0, 1'b0, 1'b0);
      check("t1_data", 32'(data_out), 32'hD);

      // 2: basic continuous frame, valid for exactly one cycle
      send_frame(4'hD);
      cyc(1'b0, 1'b0, 1'b0);
      check("t2_valid_hi", 32'(data_valid), 32'h1);
      check("t2_data", 32'(data_out), 32'hD);
      cyc(1'b0, 1'b0, 1'b0);
      check("t2_valid_lo", 32'(data_valid), 32'h0);

      // stray bit without sof while idle is ignored
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("stray_busy", 32'(busy), 32'h0);

      // 3: gapped bits 0,1,1,0
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, (i == 1 || i == 2), i == 0);
         repeat (3) begin
            cyc(1'b0, 1'b0, 1'b0);
            check("t3_cnt", 32'(bit_cnt), (i == 3) ? 32'h0 : 32'(i + 1));
         end
      end
      check("t3_data", 32'(data_out), 32'h6);

      // 4: abort after two bits, restart with all ones
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      send_frame(4'hF);
      cyc(1'b0, 1'b0, 1'b0);
      check("t4_data", 32'(data_out), 32'hF);
      check("t4_valid", 32'(data_valid), 32'h1);
      check("t4_ovr", 32'(overrun), 32'h0);
      cyc(1'b0, 1'b0, 1'b0);

      // 5: back-pressure drops the second frame
      data_ready = 1'b0;
      send_frame(4'hA);
      cyc(1'b0, 1'b0, 1'b0);
      send_frame(4'h5);
      cyc(1'b0, 1'b0, 1'b0);
      check("t5_data", 32'(data_out), 32'hA);
      check("t5_ovr", 32'(overrun), 32'h1);
      data_ready = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      check("t5_valid_lo", 32'(data_valid), 32'h0);
      check("t5_ovr_sticky", 32'(overrun), 32'h1);

      // 6: new frame completes on the cycle the held word is accepted
      do_reset();
      check("t6_ovr_clr", 32'(overrun), 32'h0);
      data_ready = 1'b0;
      send_frame(4'hC);
      cyc(1'b0, 1'b0, 1'b0);
      check("t6_held", 32'(data_out), 32'hC);
      for (int i = 0; i < int'(DW); i++) begin
         cyc(1'b1, i < 2, i == 0);
         if (i == int'(DW) - 1) data_ready = 1'b1;
      end
      cyc(1'b0, 1'b0, 1'b0);
      check("t6_valid", 32'(data_valid), 32'h1);
      check("t6_data", 32'(data_out), 32'h3);
      check("t6_ovr", 32'(overrun), 32'h0);
      cyc(1'b0, 1'b0, 1'b0);

      // end-to-end: right-shift register loaded with 9, shifting every cycle
      rs = 4'h9;
      for (int i = 0; i < int'(DW); i++) begin
         cyc(1'b1, rs[0], i == 0);
         rs = rs >> 1;
      end
      cyc(1'b0, 1'b0, 1'b0);
      check("e2e_data", 32'(data_out), 32'h9);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);

      chk_en = 1'b0;
      check("acc_count", 32'(act_q.size()), 32'(NWORD));
      check("exp_count", 32'(exp_q.size()), 32'(NWORD));
      for (int i = 0; i < int'(NWORD); i++) begin
         if (i < act_q.size()) check("acc_word", 32'(act_q[i]), 32'(lit_q[i]));
         if (i < exp_q.size()) check("model_word", 32'(exp_q[i]), 32'(lit_q[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
